// File: rtl/spiker_reader_if.sv
// Handshake bundle between spiker_reader and the spiker IP data input.
// The master side presents the spike vector; the slave side accepts it and reports completion.
interface spiker_reader_if #(
    parameter int unsigned DATA_WIDTH = 800
);
    logic [DATA_WIDTH-1:0] data_in_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  done_i;

    modport master (
        output data_in_o,
        output valid_o,
        input  ready_i,
        input  done_i
    );

    modport slave (
        input  data_in_o,
        input  valid_o,
        output ready_i,
        output done_i
    );
endinterface

// File: rtl/spiker_reader.sv
// Collects software-written input-spike words, snapshots them into a shadow vector on start,
// and hands that vector to the spiker IP over a valid/ready handshake until the IP reports done.
module spiker_reader #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned N_REG      = 25,
    parameter int unsigned N_SPIKES   = 784,
    parameter int unsigned DATA_WIDTH = 800
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_mode_i,
    input  logic [N_REG*WIDTH-1:0] spikes_q_i,
    input  logic [N_REG-1:0]       spikes_qe_i,
    input  logic                   start_q_i,
    input  logic                   start_qe_i,
    input  logic                   err_clr_i,
    spiker_reader_if.master        ip,
    output logic                   busy_o,
    output logic [N_REG-1:0]       written_o,
    output logic                   err_incomplete_o,
    output logic                   err_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Only the low N_SPIKES bits carry spikes; the padding up to DATA_WIDTH is always zero.
    localparam logic [DATA_WIDTH-1:0] SPIKE_MASK = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - N_SPIKES);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic [N_REG-1:0]      r_written;
    logic                  r_err_incomplete;
    logic                  r_err_busy;

    logic                  w_start;
    logic                  w_complete;

    assign w_start    = start_q_i & start_qe_i;
    assign w_complete = (&r_written) | test_mode_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state          <= IDLE;
            r_data           <= '0;
            r_valid          <= 1'b0;
            r_written        <= '0;
            r_err_incomplete <= 1'b0;
            r_err_busy       <= 1'b0;
        end else begin
            r_written <= r_written | spikes_qe_i;

            // Clear first so a same-cycle error set below takes priority.
            if (err_clr_i) begin
                r_err_incomplete <= 1'b0;
                r_err_busy       <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (w_complete) begin
                            r_data    <= spikes_q_i & SPIKE_MASK;
                            r_written <= spikes_qe_i;
                            r_valid   <= 1'b1;
                            r_state   <= VALID;
                        end else begin
                            r_err_incomplete <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (w_start) begin
                        r_err_busy <= 1'b1;
                    end
                    if (ip.ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_start) begin
                        r_err_busy <= 1'b1;
                    end
                    if (ip.done_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ip.data_in_o      = r_data;
    assign ip.valid_o        = r_valid;
    assign busy_o            = (r_state != IDLE);
    assign written_o         = r_written;
    assign err_incomplete_o  = r_err_incomplete;
    assign err_busy_o        = r_err_busy;

endmodule

// File: tb/tb_spiker_reader.sv
// Directed bench for spiker_reader: word collection, start/handshake/done sequencing,
// sticky errors, same-cycle write-vs-start ordering and mid-operation reset.
module tb_spiker_reader;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned N_REG      = 25;
    localparam int unsigned N_SPIKES   = 784;
    localparam int unsigned DATA_WIDTH = 800;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   test_mode = 1'b0;
    logic [N_REG*WIDTH-1:0] spikes_q = '0;
    logic [N_REG-1:0]       spikes_qe = '0;
    logic                   start_q = 1'b0;
    logic                   start_qe = 1'b0;
    logic                   err_clr = 1'b0;
    logic                   busy;
    logic [N_REG-1:0]       written;
    logic                   err_inc;
    logic                   err_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_WIDTH-1:0]  exp_vec;
    logic [DATA_WIDTH-1:0]  snap;

    spiker_reader_if #(.DATA_WIDTH(DATA_WIDTH)) ifc ();

    spiker_reader #(
        .WIDTH      (WIDTH),
        .N_REG      (N_REG),
        .N_SPIKES   (N_SPIKES),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .test_mode_i      (test_mode),
        .spikes_q_i       (spikes_q),
        .spikes_qe_i      (spikes_qe),
        .start_q_i        (start_q),
        .start_qe_i       (start_qe),
        .err_clr_i        (err_clr),
        .ip               (ifc.master),
        .busy_o           (busy),
        .written_o        (written),
        .err_incomplete_o (err_inc),
        .err_busy_o       (err_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs, input logic [DATA_WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [WIDTH-1:0] v);
        spikes_q[idx*WIDTH +: WIDTH] = v;
        spikes_qe = '0;
        spikes_qe[idx] = 1'b1;
        tick();
        spikes_qe = '0;
    endtask

    task automatic start_cmd();
        start_q = 1'b1;
        start_qe = 1'b1;
        tick();
        start_q = 1'b0;
        start_qe = 1'b0;
    endtask

    initial begin
        ifc.ready_i = 1'b0;
        ifc.done_i  = 1'b0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", ifc.valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", ifc.data_in_o, 0);
        chk("rst_written", written, 0);
        chk("rst_errs", {err_inc, err_busy}, 0);

        // T1: write all words then start
        for (int i = 0; i < 25; i++) wr(i, 32'h0100_0000 + i);
        chk("t1_written_all", written, 25'h1FF_FFFF);
        start_cmd();
        exp_vec = '0;
        for (int i = 0; i < 25; i++) exp_vec[i*32 +: 32] = 32'h0100_0000 + i;
        exp_vec[799:784] = '0;
        chk("t1_valid", ifc.valid_o, 1);
        chk("t1_busy", busy, 1);
        chk("t1_word0", ifc.data_in_o[31:0], 32'h0100_0000);
        chk("t1_pad", ifc.data_in_o[799:784], 0);
        chk("t1_word24_low", ifc.data_in_o[783:768], 16'h0018);
        chk("t1_vector", ifc.data_in_o, exp_vec);
        chk("t1_written_clr", written, 0);

        // T2: stall in VALID, then handshake and done
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_valid", ifc.valid_o, 1);
            chk("t2_hold_data", ifc.data_in_o, exp_vec);
        end
        ifc.ready_i = 1'b1;
        tick();
        ifc.ready_i = 1'b0;
        chk("t2_valid_drop", ifc.valid_o, 0);
        chk("t2_busy_wait", busy, 1);
        tick();
        chk("t2_busy_still", busy, 1);
        ifc.done_i = 1'b1;
        tick();
        ifc.done_i = 1'b0;
        chk("t2_idle", busy, 0);

        // T3: incomplete start, then test mode start
        for (int i = 0; i < 24; i++) wr(i, 32'h0100_0000 + i);
        chk("t3_written24", written, 25'h0FF_FFFF);
        start_cmd();
        chk("t3_err_inc", err_inc, 1);
        chk("t3_no_valid", ifc.valid_o, 0);
        chk("t3_no_busy", busy, 0);
        test_mode = 1'b1;
        start_cmd();
        chk("t3_tm_valid", ifc.valid_o, 1);
        chk("t3_tm_data", ifc.data_in_o, exp_vec);
        chk("t3_err_sticky", err_inc, 1);
        ifc.ready_i = 1'b1;
        tick();
        ifc.ready_i = 1'b0;
        ifc.done_i = 1'b1;
        tick();
        ifc.done_i = 1'b0;
        chk("t3_idle", busy, 0);

        // T4: busy start in WAIT, clear vs set priority
        start_cmd();
        chk("t4_valid", ifc.valid_o, 1);
        ifc.ready_i = 1'b1;
        tick();
        ifc.ready_i = 1'b0;
        start_cmd();
        chk("t4_err_busy", err_busy, 1);
        chk("t4_still_wait_busy", busy, 1);
        chk("t4_still_wait_valid", ifc.valid_o, 0);
        err_clr = 1'b1;
        start_cmd();
        chk("t4_set_wins", err_busy, 1);
        tick();
        err_clr = 1'b0;
        chk("t4_clr_busy", err_busy, 0);
        chk("t4_clr_inc", err_inc, 0);
        ifc.done_i = 1'b1;
        tick();
        ifc.done_i = 1'b0;
        chk("t4_idle", busy, 0);

        // T5: word-3 strobe coincident with accepted start
        test_mode = 1'b0;
        for (int i = 0; i < 25; i++) wr(i, 32'h0200_0000 + i);
        spikes_q[127:96] = 32'hAAAA_0003;
        spikes_qe = 25'h8;
        start_q = 1'b1;
        start_qe = 1'b1;
        tick();
        spikes_qe = '0;
        start_q = 1'b0;
        start_qe = 1'b0;
        chk("t5_written", written, 25'h8);
        chk("t5_word3", ifc.data_in_o[127:96], 32'hAAAA_0003);
        chk("t5_word2", ifc.data_in_o[95:64], 32'h0200_0002);
        ifc.ready_i = 1'b1;
        tick();
        ifc.ready_i = 1'b0;
        snap = ifc.data_in_o;
        wr(3, 32'h5555_5555);
        chk("t5_word3_held", ifc.data_in_o[127:96], 32'hAAAA_0003);
        chk("t5_written_wait", written, 25'h8);
        ifc.done_i = 1'b1;
        tick();
        ifc.done_i = 1'b0;
        chk("t5_idle", busy, 0);

        // T6: reset while stalled in VALID (leave errors set to see them cleared)
        test_mode = 1'b1;
        start_cmd();
        start_cmd();
        chk("t6_err_pre", err_busy, 1);
        chk("t6_valid_pre", ifc.valid_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", ifc.valid_o, 0);
        chk("t6_busy", busy, 0);
        chk("t6_data", ifc.data_in_o, 0);
        chk("t6_written", written, 0);
        chk("t6_errs", {err_inc, err_busy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
